// File: rtl/lsu.sv
// Load/store unit: one outstanding memory access per instruction, with lane
// steering for stores, sign/zero extension for loads and a 256-cycle bus timeout.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  mem_acc_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  cnt_r;
  logic [2:0]  lat_mode_r;
  logic [1:0]  lat_off_r;
  logic [31:0] rdata_r;
  logic        misalign_r;
  logic        bus_err_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_be_r;

  logic req_one_s;
  logic mode_ok_s;
  logic aligned_s;
  logic valid_s;
  logic misaligned_s;
  logic accept_s;
  logic ack_s;
  logic timeout_s;
  logic stall_s;

  function automatic logic [3:0] calc_be(input logic [2:0] mode, input logic [1:0] off);
    logic [3:0] be;
    case (mode)
      3'b000, 3'b011: be = 4'b0001 << off;
      3'b001, 3'b100: be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:         be = 4'b1111;
      default:        be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [2:0] mode, input logic [31:0] data);
    logic [31:0] d;
    case (mode)
      3'b000:  d = {4{data[7:0]}};
      3'b001:  d = {2{data[15:0]}};
      3'b010:  d = data;
      default: d = 32'h0000_0000;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] mode, input logic [1:0] off,
                                              input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = data[7:0];
      2'b01:   b = data[15:8];
      2'b10:   b = data[23:16];
      2'b11:   b = data[31:24];
      default: b = 8'h00;
    endcase
    h = off[1] ? data[31:16] : data[15:0];
    case (mode)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = data;
      3'b011:  r = {24'h00_0000, b};
      3'b100:  r = {16'h0000, h};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Request qualification: exactly one enable, legal mode for the direction, natural alignment
  always_comb begin
    req_one_s = rd_en ^ wr_en;
    if (wr_en) begin
      mode_ok_s = (mem_acc_mode <= 3'b010);
    end else begin
      mode_ok_s = (mem_acc_mode <= 3'b100);
    end
    case (mem_acc_mode)
      3'b001, 3'b100: aligned_s = ~addr[0];
      3'b010:         aligned_s = (addr[1:0] == 2'b00);
      default:        aligned_s = 1'b1;
    endcase
    valid_s      = req_one_s & mode_ok_s & aligned_s;
    misaligned_s = req_one_s & mode_ok_s & ~aligned_s;
  end

  // Next-state and stall decode
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    accept_s    = 1'b0;
    ack_s       = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_s) begin
          accept_s    = 1'b1;
          stall_s     = 1'b1;
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        stall_s = 1'b1;
        if (mem_ack) begin
          ack_s       = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (cnt_r == 8'hFF) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request latch, wait counter, response capture and status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= 8'h00;
      lat_mode_r  <= 3'b000;
      lat_off_r   <= 2'b00;
      rdata_r     <= 32'h0000_0000;
      misalign_r  <= 1'b0;
      bus_err_r   <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_be_r    <= 4'b0000;
    end else begin
      misalign_r <= (state_r == ST_IDLE) && misaligned_s;
      bus_err_r  <= timeout_s;
      if (accept_s) begin
        cnt_r       <= 8'h00;
        lat_mode_r  <= mem_acc_mode;
        lat_off_r   <= addr[1:0];
        mem_req_r   <= 1'b1;
        mem_we_r    <= wr_en;
        mem_addr_r  <= {addr[31:2], 2'b00};
        mem_be_r    <= calc_be(mem_acc_mode, addr[1:0]);
        mem_wdata_r <= calc_wdata(mem_acc_mode, wdata);
      end else if (ack_s) begin
        mem_req_r <= 1'b0;
        if (!mem_we_r) begin
          rdata_r <= load_extend(lat_mode_r, lat_off_r, mem_rdata);
        end
      end else if (timeout_s) begin
        mem_req_r <= 1'b0;
        if (!mem_we_r) begin
          rdata_r <= 32'h0000_0000;
        end
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r + 8'd1;
      end else begin
        mem_req_r <= 1'b0;
      end
    end
  end

  assign stall     = stall_s & rst_n;
  assign rdata     = rdata_r;
  assign misalign  = misalign_r;
  assign bus_err   = bus_err_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_be    = mem_be_r;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, randomized accesses
// against an arithmetic reference model, and reset/timeout sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en, wr_en;
  logic [2:0]  mem_acc_mode;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misalign, bus_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
    .mem_acc_mode(mem_acc_mode), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  // kind: 0 = performed access, 1 = misaligned, 2 = no-op
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] mrdata;
    int          kind;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  int          checks = 0;
  int          fails = 0;
  logic [31:0] model_rdata;
  vec_t        tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: sizes, lane masks and extension computed arithmetically.
  function automatic vec_t model(input logic rd, input logic wr, input logic [2:0] mode,
                                 input logic [31:0] a, input logic [31:0] wd, input int delay,
                                 input logic [31:0] mrd, input logic [31:0] prev);
    vec_t        v;
    int          size;
    int          off;
    logic        mode_ok;
    logic [31:0] mask;
    logic [31:0] lane;
    v.rd = rd; v.wr = wr; v.mode = mode; v.addr = a; v.wdata = wd;
    v.delay = delay; v.mrdata = mrd;
    size = (mode == 3'd2) ? 4 : ((mode == 3'd1 || mode == 3'd4) ? 2 : 1);
    off = int'(a % 32'd4);
    mode_ok = wr ? (mode <= 3'd2) : (mode <= 3'd4);
    if (!(rd ^ wr) || !mode_ok) v.kind = 2;
    else if ((a % size) != 0) v.kind = 1;
    else v.kind = 0;
    v.e_addr = a - 32'(off);
    v.e_be = 4'(((1 << size) - 1) << off);
    if (size == 4) v.e_wdata = wd;
    else if (size == 2) v.e_wdata = (wd & 32'h0000_FFFF) * 32'h0001_0001;
    else v.e_wdata = (wd & 32'h0000_00FF) * 32'h0101_0101;
    if (v.kind != 0 || wr) begin
      v.e_rdata = prev;
    end else if (delay > 255) begin
      v.e_rdata = 32'h0000_0000;
    end else begin
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
      lane = (mrd >> (8 * off)) & mask;
      if (mode < 3'd2 && lane[8 * size - 1]) lane = lane | ~mask;
      v.e_rdata = lane;
    end
    return v;
  endfunction

  // Present one instruction and follow it to the following IDLE cycle.
  task automatic do_access(input vec_t v);
    int k;
    bit fin;
    rd_en = v.rd; wr_en = v.wr; mem_acc_mode = v.mode; addr = v.addr;
    wdata = v.wdata; mem_rdata = v.mrdata; mem_ack = 1'b0;
    #1;
    chk("present_stall", stall, 32'(v.kind == 0));
    chk("present_req", mem_req, 32'h0);
    @(posedge clk); #1;
    if (v.kind == 0) begin
      k = 0;
      fin = 1'b0;
      while (!fin) begin
        mem_ack = (k == v.delay);
        chk("busy_stall", stall, 32'h1);
        chk("busy_req", mem_req, 32'h1);
        chk("busy_addr", mem_addr, v.e_addr);
        chk("busy_be", mem_be, v.e_be);
        chk("busy_we", mem_we, v.wr);
        if (v.wr) chk("busy_wdata", mem_wdata, v.e_wdata);
        fin = (k == v.delay) || (k == 255);
        k++;
        @(posedge clk); #1;
      end
      mem_ack = 1'b0;
      chk("done_stall", stall, 32'h0);
      chk("done_req", mem_req, 32'h0);
      chk("done_bus_err", bus_err, 32'(v.delay > 255));
      chk("done_rdata", rdata, v.e_rdata);
      @(posedge clk); #1;
    end else begin
      rd_en = 1'b0; wr_en = 1'b0;
      #1;
      chk("noacc_misalign", misalign, 32'(v.kind == 1));
      chk("noacc_req", mem_req, 32'h0);
      chk("noacc_stall", stall, 32'h0);
      chk("noacc_rdata", rdata, v.e_rdata);
      @(posedge clk); #1;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    chk("after_misalign", misalign, 32'h0);
    chk("after_bus_err", bus_err, 32'h0);
    chk("after_req", mem_req, 32'h0);
    chk("after_stall", stall, 32'h0);
    chk("after_rdata", rdata, v.e_rdata);
    model_rdata = v.e_rdata;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    int   p;
    logic rd, wr;
    logic [2:0] mode;

    // rd, wr, mode, addr, wdata, delay, mrdata, kind, e_addr, e_be, e_wdata, e_rdata
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0, 1,    32'h80AA_BBCC, 0, 32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 0, 32'h0, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80};
    tbl[2]  = '{1'b1, 1'b0, 3'd4, 32'h0000_0002, 32'h0, 0,    32'h8001_7FFF, 0, 32'h0000_0000, 4'b1100, 32'h0, 32'h0000_8001};
    tbl[3]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0002, 32'h0, 0,    32'h8001_7FFF, 0, 32'h0000_0000, 4'b1100, 32'h0, 32'hFFFF_8001};
    tbl[4]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'h0, 0,    32'h0, 1, 32'h0, 4'b0000, 32'h0, 32'hFFFF_8001};
    tbl[5]  = '{1'b1, 1'b0, 3'd3, 32'h0000_0103, 32'h0, 3,    32'hF100_0000, 0, 32'h0000_0100, 4'b1000, 32'h0, 32'h0000_00F1};
    tbl[6]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 2, 32'h0, 0, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'h0000_00F1};
    tbl[7]  = '{1'b0, 1'b1, 3'd3, 32'h0000_0000, 32'h5555_5555, 0, 32'h0, 2, 32'h0, 4'b0000, 32'h0, 32'h0000_00F1};
    tbl[8]  = '{1'b1, 1'b1, 3'd2, 32'h0000_0000, 32'h0, 0,    32'h0, 2, 32'h0, 4'b0000, 32'h0, 32'h0000_00F1};
    tbl[9]  = '{1'b1, 1'b0, 3'd2, 32'h0000_0008, 32'h0, 0,    32'h1357_2468, 0, 32'h0000_0008, 4'b1111, 32'h0, 32'h1357_2468};
    tbl[10] = '{1'b0, 1'b1, 3'd0, 32'h0000_0005, 32'h0000_00A5, 1, 32'h0, 0, 32'h0000_0004, 4'b0010, 32'hA5A5_A5A5, 32'h1357_2468};
    tbl[11] = '{1'b1, 1'b0, 3'd5, 32'h0000_0000, 32'h0, 0,    32'h0, 2, 32'h0, 4'b0000, 32'h0, 32'h1357_2468};
    tbl[12] = '{1'b1, 1'b0, 3'd1, 32'h0000_0011, 32'h0, 0,    32'h0, 1, 32'h0, 4'b0000, 32'h0, 32'h1357_2468};
    tbl[13] = '{1'b1, 1'b0, 3'd0, 32'h0000_0022, 32'h0, 0,    32'h007F_0000, 0, 32'h0000_0020, 4'b0100, 32'h0, 32'h0000_007F};
    tbl[14] = '{1'b1, 1'b0, 3'd2, 32'h0000_0030, 32'h0, 1000, 32'hFFFF_FFFF, 0, 32'h0000_0030, 4'b1111, 32'h0, 32'h0000_0000};
    tbl[15] = '{1'b0, 1'b1, 3'd2, 32'h0000_0034, 32'h1122_3344, 1000, 32'h0, 0, 32'h0000_0034, 4'b1111, 32'h1122_3344, 32'h0000_0000};

    // Reset, with a valid request presented to prove stall is held low
    rst_n = 1'b0; rd_en = 1'b1; wr_en = 1'b0; mem_acc_mode = 3'd2;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_stall", stall, 32'h0);
    chk("rst_req", mem_req, 32'h0);
    chk("rst_we", mem_we, 32'h0);
    chk("rst_misalign", misalign, 32'h0);
    chk("rst_bus_err", bus_err, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", mem_be, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rd_en = 1'b0; rst_n = 1'b1;
    model_rdata = 32'h0;

    for (int i = 0; i < 16; i++) do_access(tbl[i]);

    for (int i = 0; i < 60; i++) begin
      p = $urandom_range(0, 9);
      rd = (p <= 4) || (p == 8);
      wr = (p >= 5 && p <= 8);
      mode = (p <= 4) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 7) == 0) mode = 3'($urandom_range(0, 7));
      v = model(rd, wr, mode, $urandom, $urandom, $urandom_range(0, 5), $urandom, model_rdata);
      do_access(v);
    end

    // Reset in the third BUSY cycle, then a stray ack
    v = model(1'b1, 1'b0, 3'd2, 32'h0000_0040, 32'h0, 1000, 32'h0, model_rdata);
    rd_en = v.rd; wr_en = v.wr; mem_acc_mode = v.mode; addr = v.addr;
    mem_rdata = 32'hCAFE_F00D; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_req", mem_req, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_rst_stall", stall, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ack = 1'b1; rd_en = 1'b0;
    #1;
    chk("abort_req", mem_req, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_addr", mem_addr, 32'h0);
    chk("abort_be", mem_be, 32'h0);
    chk("abort_stall", stall, 32'h0);
    @(posedge clk); #1;
    chk("stray_ack_req", mem_req, 32'h0);
    chk("stray_ack_bus_err", bus_err, 32'h0);
    chk("stray_ack_stall", stall, 32'h0);
    chk("stray_ack_rdata", rdata, 32'h0);
    mem_ack = 1'b0;
    model_rdata = 32'h0;

    v = model(1'b1, 1'b0, 3'd0, 32'h0000_0081, 32'h0, 2, 32'h0000_9C00, model_rdata);
    do_access(v);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
